// File: rtl/scene_display_ctrl.sv
// Scene sequencer for the VGA colour path.
// Runs the title / play / lose / win state machine, applies scene changes
// only at frame start, flashes the lose screen, and registers the selected
// renderer colour onto the VGA pins.
module scene_display_ctrl #(
  parameter int unsigned FLASH_FRAMES = 15,       // frames per flash half-period (1..255)
  parameter int unsigned LOSE_HOLD    = 120,      // frames the lose screen ignores restart (0..255)
  parameter logic [11:0] BLACK        = 12'h000   // blanking / flash-off colour
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        start_btn,
  input  logic        restart_btn,
  input  logic        game_over,
  input  logic        game_won,
  input  logic [11:0] rgb_title,
  input  logic [11:0] rgb_play,
  input  logic [11:0] rgb_lose,
  input  logic [11:0] rgb_win,
  output logic [11:0] rgb,
  output logic [1:0]  scene,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    LOSE  = 2'd2,
    WIN   = 2'd3
  } scene_e;

  localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] HOLD_CNT   = 8'(LOSE_HOLD);

  scene_e      scene_q, scene_d;
  logic        p_start_q, p_start_d;
  logic        p_over_q, p_over_d;
  logic        p_won_q, p_won_d;
  logic        p_restart_q, p_restart_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  flash_cnt_q, flash_cnt_d;
  logic        flash_phase_q, flash_phase_d;
  logic        at_origin, at_origin_q;
  logic [11:0] rgb_q, rgb_d;

  // Requests folded with what is already pending; illegal requests vanish here.
  logic start_pend, over_pend, won_pend, restart_pend;

  assign at_origin  = (hCount == 10'd0) && (vCount == 10'd0);
  // The counters dwell on the origin for several clocks; only the first one ticks.
  assign frame_tick = at_origin && !at_origin_q;

  assign start_pend   = p_start_q   || (start_btn   && (scene_q == TITLE));
  assign over_pend    = p_over_q    || (game_over   && (scene_q == PLAY));
  assign won_pend     = p_won_q     || (game_won    && (scene_q == PLAY));
  assign restart_pend = p_restart_q || (restart_btn && ((scene_q == LOSE) || (scene_q == WIN)));

  // Scene transitions, pending-request bookkeeping and lose-screen counters.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    scene_d       = scene_q;
    p_start_d     = start_pend;
    p_over_d      = over_pend;
    p_won_d       = won_pend;
    p_restart_d   = restart_pend;
    frame_cnt_d   = frame_cnt_q;
    flash_cnt_d   = flash_cnt_q;
    flash_phase_d = flash_phase_q;

    if (frame_tick) begin
      unique case (scene_q)
        TITLE: if (start_pend) scene_d = PLAY;
        PLAY: begin
          // A simultaneous loss and win resolves to the loss.
          if (over_pend)     scene_d = LOSE;
          else if (won_pend) scene_d = WIN;
        end
        LOSE: if (restart_pend && (frame_cnt_q >= HOLD_CNT)) scene_d = TITLE;
        WIN:  if (restart_pend) scene_d = TITLE;
      endcase

      // Requests are consumed at frame start, except an early restart on the
      // lose screen, which waits for the hold period to run out.
      p_start_d   = 1'b0;
      p_over_d    = 1'b0;
      p_won_d     = 1'b0;
      p_restart_d = (scene_q == LOSE) && (scene_d == LOSE) && restart_pend;

      if (scene_d != scene_q) begin
        frame_cnt_d   = 8'd0;
        flash_cnt_d   = 8'd0;
        flash_phase_d = 1'b1;
      end else if (scene_q == LOSE) begin
        frame_cnt_d = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;
        if (flash_cnt_q == FLASH_LAST) begin
          flash_cnt_d   = 8'd0;
          flash_phase_d = !flash_phase_q;
        end else begin
          flash_cnt_d = flash_cnt_q + 8'd1;
        end
      end
    end
  end

  // Pixel colour select: blank outside the visible area and in the lose flash-off phase.
  always_comb begin
    rgb_d = BLACK;
    if (bright) begin
      unique case (scene_q)
        TITLE: rgb_d = rgb_title;
        PLAY:  rgb_d = rgb_play;
        LOSE:  rgb_d = flash_phase_q ? rgb_lose : BLACK;
        WIN:   rgb_d = rgb_win;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scene_q       <= TITLE;
      p_start_q     <= 1'b0;
      p_over_q      <= 1'b0;
      p_won_q       <= 1'b0;
      p_restart_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
      flash_cnt_q   <= 8'd0;
      flash_phase_q <= 1'b1;
      // Held high so no tick can be raised while reset is asserted.
      at_origin_q   <= 1'b1;
      rgb_q         <= BLACK;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      scene_q       <= scene_d;
      p_start_q     <= p_start_d;
      p_over_q      <= p_over_d;
      p_won_q       <= p_won_d;
      p_restart_q   <= p_restart_d;
      frame_cnt_q   <= frame_cnt_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
      at_origin_q   <= at_origin;
      rgb_q         <= rgb_d;
    end
  end

  assign rgb   = rgb_q;
  assign scene = scene_q;

endmodule

// File: tb/tb_scene_display_ctrl.sv
// Self-checking bench for scene_display_ctrl: directed scene walk-through
// followed by randomized frames, all checked against a frame-level model.
module tb_scene_display_ctrl;

  localparam int FF   = 2;   // flash half-period in frames
  localparam int HOLD = 3;   // lose-screen restart hold in frames
  localparam int H    = 4;   // small virtual frame: H x V positions
  localparam int V    = 4;

  localparam logic [3:0] R_START   = 4'b0001;
  localparam logic [3:0] R_RESTART = 4'b0010;
  localparam logic [3:0] R_OVER    = 4'b0100;
  localparam logic [3:0] R_WON     = 4'b1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        bright;
  logic [9:0]  h_cnt, v_cnt;
  logic        start_btn, restart_btn, game_over, game_won;
  logic [11:0] rgb_title, rgb_play, rgb_lose, rgb_win;
  logic [11:0] rgb;
  logic [1:0]  scene;
  logic        frame_tick;

  scene_display_ctrl #(
    .FLASH_FRAMES(FF),
    .LOSE_HOLD   (HOLD),
    .BLACK       (12'h000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bright     (bright),
    .hCount     (h_cnt),
    .vCount     (v_cnt),
    .start_btn  (start_btn),
    .restart_btn(restart_btn),
    .game_over  (game_over),
    .game_won   (game_won),
    .rgb_title  (rgb_title),
    .rgb_play   (rgb_play),
    .rgb_lose   (rgb_lose),
    .rgb_win    (rgb_win),
    .rgb        (rgb),
    .scene      (scene),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level view) ----------------
  int          m_scene;        // 0 title, 1 play, 2 lose, 3 win
  bit          m_start, m_over, m_won, m_restart;
  int          m_k;            // frame starts seen since entering the current scene
  bit          m_prev_origin;
  logic [11:0] m_rgb;
  bit          last_tick;

  task automatic m_reset();
    m_scene = 0;
    m_start = 0; m_over = 0; m_won = 0; m_restart = 0;
    m_k = 0;
    m_prev_origin = 0;
    m_rgb = 12'h000;
  endtask

  // Lose screen shows colour in even-numbered half-periods since entry.
  function automatic bit flash_on();
    return ((m_k / FF) % 2) == 0;
  endfunction

  function automatic logic [11:0] scene_src(input int s);
    case (s)
      0:       return rgb_title;
      1:       return rgb_play;
      2:       return rgb_lose;
      default: return rgb_win;
    endcase
  endfunction

  // One clock: check the tick, clock the DUT, advance the model, check registers.
  task automatic cycle();
    bit origin, tick;
    int nxt;
    bit keep;
    origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    tick   = origin && !m_prev_origin;
    #1;
    last_tick = frame_tick;
    check("frame_tick", {31'd0, frame_tick}, {31'd0, tick});
    @(posedge clk);
    m_prev_origin = origin;
    if (!bright)                        m_rgb = 12'h000;
    else if (m_scene == 2 && !flash_on()) m_rgb = 12'h000;
    else                                m_rgb = scene_src(m_scene);
    if (start_btn   && m_scene == 0)                  m_start   = 1;
    if (game_over   && m_scene == 1)                  m_over    = 1;
    if (game_won    && m_scene == 1)                  m_won     = 1;
    if (restart_btn && (m_scene == 2 || m_scene == 3)) m_restart = 1;
    if (tick) begin
      nxt = m_scene;
      case (m_scene)
        0: if (m_start) nxt = 1;
        1: if (m_over) nxt = 2; else if (m_won) nxt = 3;
        2: if (m_restart && m_k >= HOLD) nxt = 0;
        default: if (m_restart) nxt = 0;
      endcase
      keep = (m_scene == 2) && (nxt == 2) && m_restart;
      m_start = 0; m_over = 0; m_won = 0; m_restart = keep;
      if (nxt != m_scene) begin
        m_scene = nxt;
        m_k = 0;
      end else if (m_scene == 2) begin
        m_k++;
      end
    end
    #1;
    check("scene", {30'd0, scene}, m_scene);
    check("rgb", {20'd0, rgb}, {20'd0, m_rgb});
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [3:0] r);
    start_btn   = r[0];
    restart_btn = r[1];
    game_over   = r[2];
    game_won    = r[3];
  endtask

  // One clock parked at the last position, away from the origin.
  task automatic idle_cycle();
    h_cnt = 10'(H - 1);
    v_cnt = 10'(V - 1);
    drive_req(4'b0000);
    cycle();
  endtask

  // One frame starting at the origin. Directed frames hold each position
  // hold_max clocks and pulse req on the first clock of position req_pos;
  // random frames randomize dwell, colours, bright and requests.
  task automatic run_frame(input int hold_max, input bit rnd, input int req_pos,
                           input logic [3:0] req);
    int n;
    logic [3:0] r;
    for (int pos = 0; pos < H * V; pos++) begin
      n = rnd ? int'($urandom_range(1, hold_max)) : hold_max;
      for (int c = 0; c < n; c++) begin
        h_cnt = 10'(pos % H);
        v_cnt = 10'(pos / H);
        if (rnd) begin
          bright    = ($urandom_range(0, 3) != 0);
          rgb_title = 12'($urandom);
          rgb_play  = 12'($urandom);
          rgb_lose  = 12'($urandom);
          rgb_win   = 12'($urandom);
          r = 4'b0000;
          // Requests never coincide with the frame-start clock.
          if (pos >= 1)
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 31) == 0);
          drive_req(r);
        end else begin
          drive_req((pos == req_pos && c == 0) ? req : 4'b0000);
        end
        cycle();
      end
    end
    drive_req(4'b0000);
  endtask

  int n_ticks;

  initial begin
    reset = 1'b1;
    bright = 1'b0;
    h_cnt = 10'd3; v_cnt = 10'd2;
    drive_req(4'b0000);
    rgb_title = 12'h00F; rgb_play = 12'h0F0; rgb_lose = 12'hF00; rgb_win = 12'hFFF;
    m_reset();
    #1;
    check("reset_scene", {30'd0, scene}, 0);
    check("reset_rgb", {20'd0, rgb}, 0);
    check("reset_tick", {31'd0, frame_tick}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_cycle();

    // Origin held for four clocks gives a single tick.
    n_ticks = 0;
    for (int i = 0; i < 4; i++) begin
      h_cnt = 10'd0; v_cnt = 10'd0;
      cycle();
      n_ticks += int'(last_tick);
    end
    check("origin_hold_ticks", n_ticks, 1);
    idle_cycle();

    // Start mid-frame takes effect at the next frame start.
    bright = 1'b1;
    run_frame(1, 0, 5, R_START);
    check("start_waits", {30'd0, scene}, 0);
    run_frame(1, 0, -1, 4'b0000);
    check("start_play", {30'd0, scene}, 1);
    check("play_rgb", {20'd0, rgb}, 12'h0F0);

    // Asynchronous reset in the middle of a clock period.
    rgb_play = 12'hABC;
    run_frame(1, 0, -1, 4'b0000);
    check("pre_reset_rgb", {20'd0, rgb}, 12'hABC);
    #2 reset = 1'b1;
    #1;
    check("async_reset_scene", {30'd0, scene}, 0);
    check("async_reset_rgb", {20'd0, rgb}, 0);
    check("async_reset_tick", {31'd0, frame_tick}, 0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();
    rgb_play = 12'h0F0;

    // Simultaneous loss and win resolves to LOSE; then flash and restart hold.
    run_frame(1, 0, 3, R_START);
    run_frame(1, 0, 3, R_OVER | R_WON);
    run_frame(1, 0, -1, 4'b0000);          // LOSE frame 0
    check("lose_priority", {30'd0, scene}, 2);
    check("flash_f0", {20'd0, rgb}, 12'hF00);
    run_frame(1, 0, 2, R_RESTART);         // LOSE frame 1, early restart
    check("hold_f1", {30'd0, scene}, 2);
    check("flash_f1", {20'd0, rgb}, 12'hF00);
    run_frame(1, 0, -1, 4'b0000);          // LOSE frame 2
    check("hold_f2", {30'd0, scene}, 2);
    check("flash_f2", {20'd0, rgb}, 12'h000);
    run_frame(1, 0, -1, 4'b0000);          // LOSE frame 3
    check("hold_f3", {30'd0, scene}, 2);
    check("flash_f3", {20'd0, rgb}, 12'h000);
    run_frame(1, 0, -1, 4'b0000);          // pending restart honoured
    check("restart_after_hold", {30'd0, scene}, 0);
    check("title_rgb", {20'd0, rgb}, 12'h00F);

    // Win path; start in WIN is ignored, restart returns to TITLE.
    run_frame(1, 0, 4, R_START);
    run_frame(1, 0, 4, R_WON);
    run_frame(1, 0, 6, R_START);           // enters WIN, start is dropped
    check("win_scene", {30'd0, scene}, 3);
    check("win_rgb", {20'd0, rgb}, 12'hFFF);
    run_frame(1, 0, 2, R_RESTART);
    check("win_start_ignored", {30'd0, scene}, 3);
    run_frame(1, 0, -1, 4'b0000);
    check("win_restart", {30'd0, scene}, 0);
    run_frame(1, 0, -1, 4'b0000);
    check("no_jump_to_play", {30'd0, scene}, 0);

    // Randomized frames.
    for (int f = 0; f < 300; f++) run_frame(3, 1, -1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
